// File: rtl/hog_pkg.sv
// hog_pkg: shared constants and width helpers for the HOG cell pipeline.
// Histogram bins are wide enough to sum a full cell without saturation.
package hog_pkg;

   localparam int NUM_BINS      = 9;
   localparam int DEF_CELL_SIZE = 8;

   // Bin width: magnitude width plus room for CELL_SIZE^2 additions.
   function automatic int hist_w(input int dw, input int cs);
      return dw + 2 * $clog2(cs);
   endfunction

endpackage

// File: rtl/cell_histogram_if.sv
// cell_histogram_if: gradient sample stream in, per-cell histogram stream out.
// master drives samples and consumes histograms; slave is the accumulator.
interface cell_histogram_if
   import hog_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CELL_SIZE  = DEF_CELL_SIZE
);

   localparam int HW = hist_w(DATA_WIDTH, CELL_SIZE);

   logic                   mag_valid;
   logic                   mag_ready;
   logic [DATA_WIDTH-1:0]  magnitude;
   logic [3:0]             bin;
   logic                   hist_valid;
   logic                   hist_ready;
   logic [NUM_BINS*HW-1:0] hist;
   logic [7:0]             cell_x;
   logic [7:0]             cell_y;
   logic                   frame_done;

   modport master (
      output mag_valid, magnitude, bin, hist_ready,
      input  mag_ready, hist_valid, hist, cell_x, cell_y, frame_done
   );

   modport slave (
      input  mag_valid, magnitude, bin, hist_ready,
      output mag_ready, hist_valid, hist, cell_x, cell_y, frame_done
   );

endinterface

// File: rtl/hist_row_mem.sv
// hist_row_mem: one partial histogram per cell column of the current cell row.
// Asynchronous read, synchronous write; contents need no reset.
module hist_row_mem #(
   parameter int DEPTH = 79,
   parameter int WIDTH = 126,
   parameter int AW    = 7
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/cell_histogram.sv
// cell_histogram: accumulates raster-order gradient samples into per-cell
// orientation histograms, one cell row segment at a time.
module cell_histogram
   import hog_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int IMAGE_WIDTH  = 638,
   parameter int IMAGE_HEIGHT = 478,
   parameter int CELL_SIZE    = DEF_CELL_SIZE
) (
   input logic             clk,
   input logic             rst,
   cell_histogram_if.slave bus
);

   localparam int HW      = hist_w(DATA_WIDTH, CELL_SIZE);
   localparam int CELLS_X = IMAGE_WIDTH / CELL_SIZE;
   localparam int CELLS_Y = IMAGE_HEIGHT / CELL_SIZE;
   localparam int XW      = $clog2(IMAGE_WIDTH + 1);
   localparam int YW      = $clog2(IMAGE_HEIGHT + 1);
   localparam int PW      = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
   localparam int AW      = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;

   localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
   localparam logic [XW-1:0] X_LIM  = XW'(CELLS_X * CELL_SIZE);
   localparam logic [YW-1:0] Y_LIM  = YW'(CELLS_Y * CELL_SIZE);
   localparam logic [PW-1:0] P_LAST = PW'(CELL_SIZE - 1);

   typedef logic [NUM_BINS-1:0][HW-1:0] bins_t;

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [PW-1:0] px;
   logic [PW-1:0] py;
   logic [7:0]    cx;
   logic [7:0]    cy;
   bins_t         acc;
   bins_t         base;
   bins_t         sum;
   bins_t         mem_rdata;
   bins_t         hist_q;
   logic [7:0]    cx_q;
   logic [7:0]    cy_q;
   logic          hv_q;
   logic          fd_q;
   logic          accept;
   logic          in_cell;
   logic          cell_end;
   logic          emit;
   logic          mem_we;

   assign bus.mag_ready  = !hv_q || bus.hist_ready;
   assign bus.hist_valid = hv_q;
   assign bus.hist       = hist_q;
   assign bus.cell_x     = cx_q;
   assign bus.cell_y     = cy_q;
   assign bus.frame_done = fd_q;

   assign accept   = bus.mag_valid && bus.mag_ready;
   assign in_cell  = (x < X_LIM) && (y < Y_LIM);
   assign cell_end = accept && in_cell && (px == P_LAST);
   assign emit     = cell_end && (py == P_LAST);
   assign mem_we   = cell_end && (py != P_LAST);

   // First column of a cell restarts from the stored partial, or from
   // zero on the first row of a cell row so stale memory never leaks in.
   always_comb begin
      base = acc;
      if (px == '0) base = (py == '0) ? '0 : mem_rdata;
      sum = base;
      for (int k = 0; k < NUM_BINS; k++) begin
         if (bus.bin == 4'(k)) sum[k] = base[k] + HW'(bus.magnitude);
      end
   end

   hist_row_mem #(
      .DEPTH (CELLS_X),
      .WIDTH (NUM_BINS * HW),
      .AW    (AW)
   ) u_row_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (cx[AW-1:0]),
      .wdata (sum),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x  <= '0;
         y  <= '0;
         px <= '0;
         py <= '0;
         cx <= '0;
         cy <= '0;
      end else if (accept) begin
         if (x == X_LAST) begin
            x  <= '0;
            px <= '0;
            cx <= '0;
            if (y == Y_LAST) begin
               y  <= '0;
               py <= '0;
               cy <= '0;
            end else begin
               y  <= y + 1'b1;
               py <= (py == P_LAST) ? '0 : py + 1'b1;
               if (py == P_LAST) cy <= cy + 8'd1;
            end
         end else begin
            x  <= x + 1'b1;
            px <= (px == P_LAST) ? '0 : px + 1'b1;
            if (px == P_LAST) cx <= cx + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (accept && in_cell) begin
         acc <= sum;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= '0;
         cx_q   <= '0;
         cy_q   <= '0;
         hv_q   <= 1'b0;
         fd_q   <= 1'b0;
      end else begin
         if (emit) begin
            hist_q <= sum;
            cx_q   <= cx;
            cy_q   <= cy;
            hv_q   <= 1'b1;
         end else if (bus.hist_ready) begin
            hv_q <= 1'b0;
         end
         fd_q <= accept && (x == X_LAST) && (y == Y_LAST);
      end
   end

endmodule
